// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths, default depth and buffer entry type for the store buffer.
package store_buffer_pkg;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_DEPTH_DEF = 4;
  typedef struct packed {
    logic valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
  function automatic int sb_ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: DEPTH-way address compare, youngest valid matching entry wins.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int PTR_W = sb_ptr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr [DEPTH],
  input  logic [DATA_W-1:0] data [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  tail,
  input  logic [ADDR_W-1:0] AddrM,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  logic [PTR_W-1:0] idx;
  // Walk oldest to youngest so the last match (closest to tail-1) is kept.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = tail - PTR_W'(i);
      if (valid[idx] && addr[idx] == AddrM) begin
        hit = 1'b1;
        hit_data = data[idx];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO between MEM and data memory with load forwarding.
// Optional STORE_BUF_COALESCE_EN merges a store into the youngest entry on address match.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int DEPTH = SB_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StoreM,
  input  logic              LoadM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [DATA_W-1:0] DataM,
  output logic              FwdHitM,
  output logic [DATA_W-1:0] FwdDataM,
  output logic              StallSB,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemWA,
  output logic [DATA_W-1:0] MemWD,
  input  logic              MemReady,
  output logic              Empty,
  output logic [PTR_W:0]    Count
);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head, tail;
  logic              full, pop, push, coalesce, hit;
  logic [DATA_W-1:0] hit_data;

  assign full = Count == (PTR_W+1)'(DEPTH);
  assign Empty = Count == '0;
  assign MemWE = ~Empty & ~LoadM;
  assign MemWA = addr_q[head];
  assign MemWD = data_q[head];
  assign pop = MemWE & MemReady;
`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail - 1'b1;
  // A single remaining entry being drained this cycle cannot absorb the store.
  assign coalesce = StoreM & valid_q[youngest] & (addr_q[youngest] == AddrM) & ~(pop & (head == youngest));
`else
  assign coalesce = 1'b0;
`endif
  assign StallSB = StoreM & full & ~pop & ~coalesce;
  assign push = StoreM & ~StallSB & ~coalesce;
  assign FwdHitM = LoadM & ~StoreM & hit;
  assign FwdDataM = FwdHitM ? hit_data : '0;

  store_buffer_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .addr(addr_q), .data(data_q), .valid(valid_q), .tail(tail), .AddrM(AddrM),
    .hit(hit), .hit_data(hit_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      Count <= '0;
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head <= head + 1'b1;
      end
      // Push after pop so a full push+pop reuses the slot being freed.
      if (push) begin
        valid_q[tail] <= 1'b1;
        addr_q[tail] <= AddrM;
        data_q[tail] <= DataM;
        tail <= tail + 1'b1;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (coalesce) data_q[youngest] <= DataM;
`endif
      Count <= (push && !pop) ? Count + 1'b1 : (pop && !push) ? Count - 1'b1 : Count;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random + directed stimulus against a queue model; drained writes scoreboarded.
module tb_store_buffer;
  import store_buffer_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic StoreM = 1'b0, LoadM = 1'b0, MemReady = 1'b0;
  logic [31:0] AddrM = '0, DataM = '0;
  logic FwdHitM, StallSB, MemWE, Empty;
  logic [31:0] FwdDataM, MemWA, MemWD;
  logic [2:0] Count;
  int checks = 0, errors = 0;
  sb_entry_t mq[$];
  sb_entry_t exp_wr[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .StoreM(StoreM), .LoadM(LoadM), .AddrM(AddrM), .DataM(DataM),
    .FwdHitM(FwdHitM), .FwdDataM(FwdDataM), .StallSB(StallSB), .MemWE(MemWE),
    .MemWA(MemWA), .MemWD(MemWD), .MemReady(MemReady), .Empty(Empty), .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Monitor: every accepted memory write must be the oldest outstanding store.
  always @(negedge clk) begin
    sb_entry_t e;
    if (!rst && MemWE && MemReady) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain: unexpected write addr %0h data %0h", MemWA, MemWD);
      end else begin
        e = exp_wr.pop_front();
        chk("drain addr", {32'b0, MemWA}, {32'b0, e.addr});
        chk("drain data", {32'b0, MemWD}, {32'b0, e.data});
      end
    end
  end

  task automatic step(input logic s, input logic l, input logic [31:0] a, input logic [31:0] d, input logic r);
    logic pop_e, co_e, stall_e, hit_e;
    logic [31:0] fd_e;
    sb_entry_t tmp;
    StoreM = s; LoadM = l; AddrM = a; DataM = d; MemReady = r;
    @(negedge clk);
    pop_e = mq.size() > 0 && !l && r;
    co_e = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    co_e = s && mq.size() > 0 && mq[$].addr == a && !(pop_e && mq.size() == 1);
`endif
    stall_e = s && mq.size() == DEPTH && !pop_e && !co_e;
    hit_e = 1'b0;
    fd_e = '0;
    if (l && !s) foreach (mq[i]) if (mq[i].addr == a) begin hit_e = 1'b1; fd_e = mq[i].data; end
    chk("Count", 64'(Count), 64'(mq.size()));
    chk("Empty", 64'(Empty), 64'(mq.size() == 0));
    chk("MemWE", 64'(MemWE), 64'(mq.size() > 0 && !l));
    chk("StallSB", 64'(StallSB), 64'(stall_e));
    chk("FwdHitM", 64'(FwdHitM), 64'(hit_e));
    chk("FwdDataM", 64'(FwdDataM), 64'(fd_e));
    @(posedge clk);
    if (pop_e) tmp = mq.pop_front();
    if (co_e) begin
      mq[$].data = d;
      if (exp_wr.size() > 0) exp_wr[$].data = d;
    end else if (s && !stall_e) begin
      mq.push_back('{1'b1, a, d});
      exp_wr.push_back('{1'b1, a, d});
    end
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #12;
    chk("reset Count", 64'(Count), 0);
    chk("reset Empty", 64'(Empty), 1);
    chk("reset MemWE", 64'(MemWE), 0);
    chk("reset FwdHitM", 64'(FwdHitM), 0);
    chk("reset FwdDataM", 64'(FwdDataM), 0);
    chk("reset StallSB", 64'(StallSB), 0);
    @(posedge clk); #1 rst = 1'b0;
    // Mid-operation reset with three buffered stores.
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 32'(i * 8), 32'(i), 1'b0);
    chk("pre-reset Count", 64'(Count), 3);
    StoreM = 1'b0; MemReady = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async reset Count", 64'(Count), 0);
    chk("async reset Empty", 64'(Empty), 1);
    chk("async reset MemWE", 64'(MemWE), 0);
    mq.delete();
    exp_wr.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
    // Fill to full, stall on the fifth, then push+pop when memory is ready.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i * 16), 32'(32'h100 + i), 1'b0);
    step(1'b1, 1'b0, 32'h50, 32'h105, 1'b1);
    chk("push+pop Count", 64'(Count), 4);
    drain();
    // Youngest-match forwarding and a miss.
    step(1'b1, 1'b0, 32'h20, 32'hAAAA, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'hBBBB, 1'b0);
    step(1'b0, 1'b1, 32'h20, '0, 1'b0);
    step(1'b0, 1'b1, 32'h24, '0, 1'b0);
    step(1'b1, 1'b1, 32'h20, 32'hCCCC, 1'b0);
    // Loads hold the memory port even with MemReady high.
    repeat (3) step(1'b0, 1'b1, 32'h30, '0, 1'b1);
    drain();
    // Wrap-around through ten store/drain pairs.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'(32'h200 + 4 * i), 32'(i + 1), 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1);
    end
    chk("wrap Empty", 64'(Empty), 1);
    // Full buffer, store to youngest address.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i * 16), 32'(i), 1'b0);
    step(1'b1, 1'b0, 32'h40, 32'h7, 1'b0);
    drain();
    // Randomised traffic over a small address set to provoke hits and stalls.
    repeat (400) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                      32'($urandom_range(1, 4) * 16), $urandom, 1'($urandom_range(0, 2) != 0));
    drain();
    chk("final Empty", 64'(Empty), 1);
    chk("scoreboard empty", 64'(exp_wr.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
